ms_mul_seq_ctrl: RTL and testbench

//  Sequencer directly upstream of ms_serial_by4_mul (and consumer of its result).

---
 rtl/ms_mul_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ms_mul_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ms_mul_seq_ctrl.sv
// ms_mul_seq_ctrl
// Sequencer for a serial multiplier: takes one operand vector per in-side
// handshake, holds the multiplier in reset for a fixed number of cycles, runs
// it until its done rises (or a watchdog expires), lets the accumulator
// settle, captures the product and offers it on a valid/ready result port.
module ms_mul_seq_ctrl #(
    parameter int DATA_WIDTH   = 5,
    parameter int NUM_INPUTS   = 2,
    parameter int RES_WIDTH    = DATA_WIDTH * NUM_INPUTS,
    parameter int CLR_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 1,
    parameter int MAX_CYCLES   = 2 ** (DATA_WIDTH * NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                             mul_rst,
    output logic                             mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_bin_in,
    input  logic                             mul_done,
    input  logic [RES_WIDTH-1:0]             mul_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RES_WIDTH-1:0]             out_data,
    output logic                             out_err,
    output logic [15:0]                      op_cnt
);

    localparam int IN_W   = NUM_INPUTS * DATA_WIDTH;
    localparam int CNT_W  = $clog2(MAX_CYCLES + 1);
    localparam int PH_MAX = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [PH_W-1:0]  CLR_LAST   = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              done_q_r;
    logic              err_pend_r;
    logic [CNT_W-1:0]  wd_cnt_r;
    logic [PH_W-1:0]   phase_cnt_r;

    logic              in_hs_s;
    logic              out_hs_s;
    logic              done_edge_s;
    logic              wd_limit_s;
    logic              clr_last_s;
    logic              drain_last_s;

    logic              in_ready_nxt_s;
    logic              mul_rst_nxt_s;
    logic              mul_en_nxt_s;
    logic              out_valid_nxt_s;

    assign in_hs_s      = in_valid & in_ready;
    assign out_hs_s     = out_valid & out_ready;
    assign done_edge_s  = mul_done & ~done_q_r;
    assign wd_limit_s   = (wd_cnt_r == WD_LIMIT);
    assign clr_last_s   = (phase_cnt_r == CLR_LAST);
    assign drain_last_s = (phase_cnt_r == DRAIN_LAST);

    // State register plus the registered handshake/control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            mul_rst   <= 1'b1;
            mul_en    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            in_ready  <= in_ready_nxt_s;
            mul_rst   <= mul_rst_nxt_s;
            mul_en    <= mul_en_nxt_s;
            out_valid <= out_valid_nxt_s;
        end
    end

    // Next-state decision; a done edge takes priority over the watchdog limit.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_hs_s) state_nxt_s = ST_CLR;
                else         state_nxt_s = ST_IDLE;
            end
            ST_CLR: begin
                if (clr_last_s) state_nxt_s = ST_RUN;
                else            state_nxt_s = ST_CLR;
            end
            ST_RUN: begin
                if (done_edge_s || wd_limit_s) state_nxt_s = ST_DRAIN;
                else                           state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (drain_last_s) state_nxt_s = ST_OUT;
                else              state_nxt_s = ST_DRAIN;
            end
            ST_OUT: begin
                if (out_hs_s) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        mul_rst_nxt_s   = 1'b0;
        mul_en_nxt_s    = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s = 1'b1;
                mul_rst_nxt_s  = 1'b1;
            end
            ST_CLR: begin
                mul_rst_nxt_s = 1'b1;
            end
            ST_RUN: begin
                mul_en_nxt_s = 1'b1;
            end
            ST_DRAIN: begin
                mul_en_nxt_s = 1'b0;
            end
            ST_OUT: begin
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s = 1'b1;
                mul_rst_nxt_s  = 1'b1;
            end
        endcase
    end

    // Datapath: operand latch, done history, watchdog, phase counter, capture and op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_bin_in  <= {IN_W{1'b0}};
            done_q_r    <= 1'b0;
            wd_cnt_r    <= {CNT_W{1'b0}};
            phase_cnt_r <= {PH_W{1'b0}};
            err_pend_r  <= 1'b0;
            out_data    <= {RES_WIDTH{1'b0}};
            out_err     <= 1'b0;
            op_cnt      <= 16'd0;
        end else begin
            // Operands are only ever taken while idle.
            if (state_r == ST_IDLE && in_hs_s) begin
                mul_bin_in <= in_data;
            end

            // Done history is meaningful only in RUN; cleared everywhere else.
            if (state_r == ST_RUN) begin
                done_q_r <= mul_done;
            end else begin
                done_q_r <= 1'b0;
            end

            // Watchdog counts RUN cycles only and sits at zero otherwise.
            if (state_r == ST_RUN && !done_edge_s && !wd_limit_s) begin
                wd_cnt_r <= wd_cnt_r + CNT_W'(1);
            end else begin
                wd_cnt_r <= {CNT_W{1'b0}};
            end

            // Shared dwell counter for the CLR and DRAIN phases.
            if ((state_r == ST_CLR && !clr_last_s) || (state_r == ST_DRAIN && !drain_last_s)) begin
                phase_cnt_r <= phase_cnt_r + PH_W'(1);
            end else begin
                phase_cnt_r <= {PH_W{1'b0}};
            end

            // Timeout flag for the current operation.
            if (state_r == ST_RUN) begin
                if (done_edge_s)     err_pend_r <= 1'b0;
                else if (wd_limit_s) err_pend_r <= 1'b1;
                else                 err_pend_r <= err_pend_r;
            end else if (state_r == ST_IDLE) begin
                err_pend_r <= 1'b0;
            end else begin
                err_pend_r <= err_pend_r;
            end

            // Product capture once the accumulator has had time to settle.
            if (state_r == ST_DRAIN && drain_last_s) begin
                out_data <= mul_result;
                out_err  <= err_pend_r;
            end

            // Completed result handshakes, wrapping at 16 bits.
            if (state_r == ST_OUT && out_hs_s) begin
                op_cnt <= op_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ms_mul_seq_ctrl.sv
// Bench for ms_mul_seq_ctrl: a behavioural multiplier stands in for the
// serial multiplier, and every expected result/latency comes from plain
// arithmetic on the operands and the programmed done latency.
module tb_ms_mul_seq_ctrl;

    localparam int DW   = 5;
    localparam int NI   = 2;
    localparam int RW   = DW * NI;
    localparam int CLR  = 2;
    localparam int DRN  = 1;
    localparam int MAXC = 20;
    localparam logic [RW-1:0] PARTIAL = 10'h155;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [NI*DW-1:0]  in_data;
    logic              mul_rst;
    logic              mul_en;
    logic [NI*DW-1:0]  mul_bin_in;
    logic              mul_done;
    logic [RW-1:0]     mul_result;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_data;
    logic              out_err;
    logic [15:0]       op_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    int m_lat;
    bit m_hang;
    int m_cnt;

    always #5 clk = ~clk;

    ms_mul_seq_ctrl #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .RES_WIDTH(RW),
        .CLR_CYCLES(CLR), .DRAIN_CYCLES(DRN), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mul_rst(mul_rst), .mul_en(mul_en), .mul_bin_in(mul_bin_in),
        .mul_done(mul_done), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .op_cnt(op_cnt)
    );

    // Behavioural multiplier: done rises after m_lat enabled cycles, the final
    // product appears one cycle after done; before that it shows a partial value.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt      <= 0;
            mul_done   <= 1'b0;
            mul_result <= '0;
        end else if (mul_rst) begin
            m_cnt      <= 0;
            mul_done   <= 1'b0;
            mul_result <= PARTIAL;
        end else begin
            if (mul_en && !m_hang) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_lat) mul_done <= 1'b1;
            end
            if (mul_done) mul_result <= RW'(mul_bin_in[DW-1:0]) * RW'(mul_bin_in[2*DW-1:DW]);
        end
    end

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        bit            hang;
        int            hold;
        logic [RW-1:0] exp_d;
        bit            exp_e;
        int            exp_cyc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: product if done is seen within the watchdog window, else
    // timeout with the partial value; latency counted from the handshake cycle.
    function automatic vec_t ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input int lat, input bit hang, input int hold);
        vec_t v;
        int run;
        v.a = a; v.b = b; v.lat = lat; v.hang = hang; v.hold = hold;
        if (!hang && (lat + 1) <= MAXC) begin
            run     = lat + 1;
            v.exp_d = RW'(int'(a) * int'(b));
            v.exp_e = 1'b0;
        end else begin
            run     = MAXC;
            v.exp_d = PARTIAL;
            v.exp_e = 1'b1;
        end
        v.exp_cyc = CLR + run + DRN + 1;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int  cyc;
        bit  seen;
        logic [RW-1:0] d_hold;
        logic          e_hold;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_wait", in_ready, 1);
        m_lat    = v.lat;
        m_hang   = v.hang;
        in_data  = {v.b, v.a};
        in_valid = 1'b1;
        out_ready = (v.hold == 0);
        @(posedge clk);
        @(negedge clk);
        cyc  = 1;
        seen = 0;
        while (!seen && cyc <= 100) begin
            if (out_valid) begin
                seen = 1;
            end else begin
                chk("in_ready_busy", in_ready, 0);
                chk("bin_hold", mul_bin_in, {v.b, v.a});
                if (cyc <= CLR) begin
                    chk("clr_mul_rst", mul_rst, 1);
                    chk("clr_mul_en", mul_en, 0);
                end
                if (cyc == CLR + 1) begin
                    chk("run_mul_rst", mul_rst, 0);
                    chk("run_mul_en", mul_en, 1);
                end
                in_valid = 1'($urandom % 2);
                in_data  = RW'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        chk("out_valid_seen", seen, 1);
        chk("latency", cyc, v.exp_cyc);
        chk("out_data", out_data, v.exp_d);
        chk("out_err", out_err, v.exp_e);
        chk("en_off_at_out", mul_en, 0);
        d_hold = out_data;
        e_hold = out_err;
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'($urandom % 2);
            in_data  = RW'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, d_hold);
            chk("hold_err", out_err, e_hold);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_op_cnt", op_cnt, exp_ops);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_ops++;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_mul_rst", mul_rst, 1);
        chk("op_cnt", op_cnt, exp_ops);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;
        // Hand-written records with literal expectations.
        vecs[0] = '{5'd16, 5'd16, 4,  1'b0, 0,  10'd256, 1'b0, 9};
        vecs[1] = '{5'd0,  5'd31, 1,  1'b0, 0,  10'd0,   1'b0, 6};
        vecs[2] = '{5'd31, 5'd31, 3,  1'b0, 0,  10'd961, 1'b0, 8};
        vecs[3] = '{5'd3,  5'd3,  1,  1'b1, 0,  10'h155, 1'b1, 24};
        vecs[4] = '{5'd7,  5'd9,  19, 1'b0, 0,  10'd63,  1'b0, 24};
        vecs[5] = '{5'd7,  5'd9,  20, 1'b0, 0,  10'h155, 1'b1, 24};
        vecs[6] = '{5'd5,  5'd6,  2,  1'b0, 10, 10'd30,  1'b0, 7};
        for (int i = 7; i < 16; i++) begin
            vecs[i] = ref_op(DW'($urandom), DW'($urandom), int'($urandom_range(1, 22)),
                             1'b0, int'($urandom_range(0, 3)));
        end

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_lat = 1; m_hang = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_rst", mul_rst, 1);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_cnt", op_cnt, 0);

        for (int i = 0; i < 16; i++) run_op(vecs[i]);

        // Reset five cycles into RUN aborts the operation.
        m_lat = 15; m_hang = 1'b0;
        in_data = {5'd9, 5'd9}; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (CLR + 5 - 1) @(negedge clk);
        chk("pre_abort_en", mul_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_mul_rst", mul_rst, 1);
        chk("abort_mul_en", mul_en, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_err", out_err, 0);
        chk("abort_op_cnt", op_cnt, 0);
        chk("abort_bin", mul_bin_in, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        @(negedge clk);
        v = ref_op(5'd2, 5'd2, 3, 1'b0, 0);
        chk("ref_after_abort", v.exp_d, 4);
        run_op(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
